// File: rtl/car_ctl.sv
// Per-player drag-race car controller: frame-ticked race FSM driving car_xpos,
// rpm, gear and race timing for draw_car and the HUD.
module car_ctl #(
    parameter int X_START          = 256,
    parameter int X_FINISH         = 900,
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int RPM_RISE         = 4,
    parameter int RPM_FALL         = 2,
    parameter int RPM_MAX          = 255,
    parameter int GEARS            = 5,
    parameter int FRAC_BITS        = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_vsync_in,
    input  logic        i_start,
    input  logic        i_gas,
    input  logic        i_shift_up,
    output logic [10:0] o_car_xpos,
    output logic [7:0]  o_rpm,
    output logic [2:0]  o_gear,
    output logic [7:0]  o_countdown,
    output logic [15:0] o_race_frames,
    output logic [1:0]  o_state,
    output logic        o_finished
);

    localparam int PW = 11 + FRAC_BITS + 1;

    localparam logic [PW-1:0] LP_POS0   = PW'(X_START) << FRAC_BITS;
    localparam logic [10:0]   LP_XSTART = 11'(X_START);
    localparam logic [10:0]   LP_XFIN   = 11'(X_FINISH);
    localparam logic [11:0]   LP_XFIN12 = 12'(X_FINISH);
    localparam logic [8:0]    LP_RISE   = 9'(RPM_RISE);
    localparam logic [8:0]    LP_MAX9   = 9'(RPM_MAX);
    localparam logic [7:0]    LP_MAX    = 8'(RPM_MAX);
    localparam logic [7:0]    LP_FALL   = 8'(RPM_FALL);
    localparam logic [7:0]    LP_CD     = 8'(COUNTDOWN_FRAMES);
    localparam logic [2:0]    LP_GEARS  = 3'(GEARS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CD   = 2'd1,
        S_RACE = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_vsync_prev;
    logic [10:0]     r_xpos;
    logic [7:0]      r_rpm;
    logic [2:0]      r_gear;
    logic [7:0]      r_countdown;
    logic [15:0]     r_race_frames;
    logic            r_finished;
    logic [PW-1:0]   r_pos_fx;

    logic            w_tick;
    logic            w_clear;
    logic            w_shift;
    logic [2:0]      w_gear_s;
    logic [7:0]      w_rpm_s;
    logic [8:0]      w_rpm_up;
    logic [7:0]      w_rpm_dn;
    logic [7:0]      w_rpm_new;
    logic [10:0]     w_prod;
    logic [PW-1:0]   w_pos_next;
    logic [11:0]     w_x_next;
    logic            w_done;
    logic [15:0]     w_frames_next;

    assign w_tick  = i_vsync_in & ~r_vsync_prev;
    assign w_clear = i_rst | ((r_state == S_FIN) & i_start);

    // A shift is resolved before the tick, so the tick sees the new gear and halved rpm.
    assign w_shift  = (r_state == S_RACE) & i_shift_up & (r_gear < LP_GEARS);
    assign w_gear_s = w_shift ? r_gear + 3'd1 : r_gear;
    assign w_rpm_s  = w_shift ? {1'b0, r_rpm[7:1]} : r_rpm;

    assign w_rpm_up  = {1'b0, w_rpm_s} + LP_RISE;
    assign w_rpm_dn  = (w_rpm_s > LP_FALL) ? w_rpm_s - LP_FALL : 8'd0;
    assign w_rpm_new = i_gas ? ((w_rpm_up > LP_MAX9) ? LP_MAX : w_rpm_up[7:0])
                             : w_rpm_dn;

    assign w_prod     = {3'b000, w_rpm_new} * {8'h00, w_gear_s};
    assign w_pos_next = r_pos_fx + PW'(w_prod);
    assign w_x_next   = w_pos_next[PW-1:FRAC_BITS];
    assign w_done     = (w_x_next >= LP_XFIN12);

    assign w_frames_next = (r_race_frames == 16'hFFFF) ? r_race_frames
                                                       : r_race_frames + 16'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vsync_prev <= 1'b0;
        end else begin
            r_vsync_prev <= i_vsync_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_clear) begin
            r_state       <= S_IDLE;
            r_xpos        <= LP_XSTART;
            r_rpm         <= 8'd0;
            r_gear        <= 3'd1;
            r_countdown   <= 8'd0;
            r_race_frames <= 16'd0;
            r_finished    <= 1'b0;
            r_pos_fx      <= LP_POS0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state     <= S_CD;
                        r_countdown <= LP_CD;
                    end
                end
                S_CD: begin
                    if (w_tick) begin
                        r_rpm       <= w_rpm_new;
                        r_countdown <= r_countdown - 8'd1;
                        if (r_countdown == 8'd1) begin
                            r_state <= S_RACE;
                        end
                    end
                end
                S_RACE: begin
                    r_gear <= w_gear_s;
                    r_rpm  <= w_rpm_s;
                    if (w_tick) begin
                        r_rpm         <= w_rpm_new;
                        r_pos_fx      <= w_pos_next;
                        r_race_frames <= w_frames_next;
                        if (w_done) begin
                            r_xpos     <= LP_XFIN;
                            r_state    <= S_FIN;
                            r_finished <= 1'b1;
                        end else begin
                            r_xpos <= w_x_next[10:0];
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_FIN;
                end
            endcase
        end
    end

    assign o_car_xpos    = r_xpos;
    assign o_rpm         = r_rpm;
    assign o_gear        = r_gear;
    assign o_countdown   = r_countdown;
    assign o_race_frames = r_race_frames;
    assign o_state       = r_state;
    assign o_finished    = r_finished;

endmodule
